time_of_day_counter: RTL and testbench

// - Downstream of the 1 Hz second counter: consumes its one-cycle second_inc pulse and keeps

---
 rtl/time_of_day_counter.sv | 127 ++++++++++++
 tb/tb_time_of_day_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/time_of_day_counter.sv
// Time-of-day counter: HH:MM:SS in packed BCD, 24 h. It advances on second_inc_i,
// is loaded with hours/minutes by the MSF decoder, and emits minute/hour/day carry
// pulses.
module time_of_day_counter #(
    parameter logic [7:0] RST_HOURS   = 8'h00,
    parameter logic [7:0] RST_MINUTES = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       second_inc_i,
    input  logic       load_i,
    input  logic [7:0] load_hours_i,
    input  logic [7:0] load_minutes_i,
    output logic [7:0] hours_o,
    output logic [7:0] minutes_o,
    output logic [7:0] seconds_o,
    output logic       minute_inc_o,
    output logic       hour_inc_o,
    output logic       day_inc_o,
    output logic       valid_o,
    output logic       load_err_o
);

    logic [7:0] hours_q, hours_d;
    logic [7:0] minutes_q, minutes_d;
    logic [7:0] seconds_q, seconds_d;
    logic       minute_inc_q, minute_inc_d;
    logic       hour_inc_q, hour_inc_d;
    logic       day_inc_q, day_inc_d;
    logic       valid_q, valid_d;
    logic       load_err_q, load_err_d;

    logic hours_legal;
    logic minutes_legal;
    logic load_ok;

    // BCD increment of a legal two-digit value. The caller handles the wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Load value legality: hours 00..23, minutes 00..59, every nibble a decimal digit.
    always_comb begin
        hours_legal   = ((load_hours_i[7:4] < 4'd2) && (load_hours_i[3:0] <= 4'd9)) ||
                        ((load_hours_i[7:4] == 4'd2) && (load_hours_i[3:0] <= 4'd3));
        minutes_legal = (load_minutes_i[7:4] <= 4'd5) && (load_minutes_i[3:0] <= 4'd9);
        load_ok       = load_i && hours_legal && minutes_legal;
    end

    // Next-state: a legal load takes priority over and drops a coincident increment.
    always_comb begin
        hours_d      = hours_q;
        minutes_d    = minutes_q;
        seconds_d    = seconds_q;
        valid_d      = valid_q;
        minute_inc_d = 1'b0;
        hour_inc_d   = 1'b0;
        day_inc_d    = 1'b0;
        load_err_d   = 1'b0;

        if (load_ok) begin
            hours_d   = load_hours_i;
            minutes_d = load_minutes_i;
            seconds_d = 8'h00;
            valid_d   = 1'b1;
        end else begin
            load_err_d = load_i;
            if (second_inc_i) begin
                if (seconds_q == 8'h59) begin
                    seconds_d    = 8'h00;
                    minute_inc_d = 1'b1;
                    if (minutes_q == 8'h59) begin
                        minutes_d  = 8'h00;
                        hour_inc_d = 1'b1;
                        if (hours_q == 8'h23) begin
                            hours_d   = 8'h00;
                            day_inc_d = 1'b1;
                        end else begin
                            hours_d = bcd_inc(hours_q);
                        end
                    end else begin
                        minutes_d = bcd_inc(minutes_q);
                    end
                end else begin
                    seconds_d = bcd_inc(seconds_q);
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hours_q      <= RST_HOURS;
            minutes_q    <= RST_MINUTES;
            seconds_q    <= 8'h00;
            valid_q      <= 1'b0;
            minute_inc_q <= 1'b0;
            hour_inc_q   <= 1'b0;
            day_inc_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            valid_q      <= valid_d;
            minute_inc_q <= minute_inc_d;
            hour_inc_q   <= hour_inc_d;
            day_inc_q    <= day_inc_d;
            load_err_q   <= load_err_d;
        end
    end

    assign hours_o      = hours_q;
    assign minutes_o    = minutes_q;
    assign seconds_o    = seconds_q;
    assign minute_inc_o = minute_inc_q;
    assign hour_inc_o   = hour_inc_q;
    assign day_inc_o    = day_inc_q;
    assign valid_o      = valid_q;
    assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: the driver queues the expected registered state for each
// driven cycle, and the monitor pops and compares it just after the following clock edge.
module tb_time_of_day_counter;

    typedef struct packed {
        logic [7:0] hours;
        logic [7:0] minutes;
        logic [7:0] seconds;
        logic       minute_inc;
        logic       hour_inc;
        logic       day_inc;
        logic       valid;
        logic       load_err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       second_inc = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hours = 8'h00;
    logic [7:0] load_minutes = 8'h00;
    logic [7:0] hours, minutes, seconds;
    logic       minute_inc, hour_inc, day_inc, valid, load_err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    time_of_day_counter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .second_inc_i   (second_inc),
        .load_i         (load),
        .load_hours_i   (load_hours),
        .load_minutes_i (load_minutes),
        .hours_o        (hours),
        .minutes_o      (minutes),
        .seconds_o      (seconds),
        .minute_inc_o   (minute_inc),
        .hour_inc_o     (hour_inc),
        .day_inc_o      (day_inc),
        .valid_o        (valid),
        .load_err_o     (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic exp_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic mi, input logic hi, input logic di,
                                input logic v, input logic e);
        mk = '{h, m, s, mi, hi, di, v, e};
    endfunction

    // One driven cycle: apply inputs at the falling edge, queue the state expected after the
    // next rising edge.
    task automatic cyc(input logic r, input logic si, input logic ld, input logic [7:0] lh,
                       input logic [7:0] lm, input exp_t e);
        @(negedge clk);
        rst          = r;
        second_inc   = si;
        load         = ld;
        load_hours   = lh;
        load_minutes = lm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input exp_t e);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, e);
    endtask

    // n second pulses from seconds s0 at fixed h:m; n must keep seconds within 59.
    task automatic pulses(input int n, input int s0, input logic [7:0] h, input logic [7:0] m,
                          input logic v);
        for (int i = 1; i <= n; i++)
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, mk(h, m, bcd(s0 + i), 0, 0, 0, v, 0));
    endtask

    // Monitor: one comparison per queued entry, sampled 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = mk(hours, minutes, seconds, minute_inc, hour_inc, day_inc, valid, load_err);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL check%0d got %h:%h:%h mi%b hi%b di%b v%b err%b want %h:%h:%h mi%b hi%b di%b v%b err%b",
                         checks, a.hours, a.minutes, a.seconds, a.minute_inc, a.hour_inc,
                         a.day_inc, a.valid, a.load_err, e.hours, e.minutes, e.seconds,
                         e.minute_inc, e.hour_inc, e.day_inc, e.valid, e.load_err);
            end
        end
    end

    initial begin
        int budget;

        // Reset and idle.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        idle(10, mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));

        // 59 seconds, then the minute carry lasting one cycle.
        pulses(59, 0, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, mk(8'h00, 8'h01, 8'h00, 1, 0, 0, 0, 0));
        idle(2, mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 0));

        // Illegal loads, without and with a coincident second pulse.
        cyc(1'b0, 1'b0, 1'b1, 8'h24, 8'h00, mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 1));
        cyc(1'b0, 1'b0, 1'b1, 8'h1A, 8'h00, mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 1));
        cyc(1'b0, 1'b0, 1'b1, 8'h12, 8'h60, mk(8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 1));
        cyc(1'b0, 1'b1, 1'b1, 8'h24, 8'h00, mk(8'h00, 8'h01, 8'h01, 0, 0, 0, 0, 1));
        cyc(1'b0, 1'b1, 1'b1, 8'h1A, 8'h00, mk(8'h00, 8'h01, 8'h02, 0, 0, 0, 0, 1));
        cyc(1'b0, 1'b1, 1'b1, 8'h12, 8'h60, mk(8'h00, 8'h01, 8'h03, 0, 0, 0, 0, 1));
        idle(1, mk(8'h00, 8'h01, 8'h03, 0, 0, 0, 0, 0));

        // Load 23:59, then 60 seconds: all three carries in one cycle.
        cyc(1'b0, 1'b0, 1'b1, 8'h23, 8'h59, mk(8'h23, 8'h59, 8'h00, 0, 0, 0, 1, 0));
        pulses(59, 0, 8'h23, 8'h59, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, mk(8'h00, 8'h00, 8'h00, 1, 1, 1, 1, 0));
        idle(2, mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0));

        // Hours units wrap 09 -> 10.
        cyc(1'b0, 1'b0, 1'b1, 8'h09, 8'h59, mk(8'h09, 8'h59, 8'h00, 0, 0, 0, 1, 0));
        pulses(59, 0, 8'h09, 8'h59, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, mk(8'h10, 8'h00, 8'h00, 1, 1, 0, 1, 0));

        // Illegal load after valid leaves valid and time alone.
        cyc(1'b0, 1'b0, 1'b1, 8'h30, 8'h00, mk(8'h10, 8'h00, 8'h00, 0, 0, 0, 1, 1));

        // Load 12:34 mid-count at seconds 27.
        pulses(27, 0, 8'h10, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h12, 8'h34, mk(8'h12, 8'h34, 8'h00, 0, 0, 0, 1, 0));
        idle(1, mk(8'h12, 8'h34, 8'h00, 0, 0, 0, 1, 0));

        // Load with coincident increment at 11:59:59: the load wins.
        cyc(1'b0, 1'b0, 1'b1, 8'h11, 8'h59, mk(8'h11, 8'h59, 8'h00, 0, 0, 0, 1, 0));
        pulses(59, 0, 8'h11, 8'h59, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'h12, 8'h00, mk(8'h12, 8'h00, 8'h00, 0, 0, 0, 1, 0));
        idle(1, mk(8'h12, 8'h00, 8'h00, 0, 0, 0, 1, 0));

        // Reset at 05:43:21 with a coincident increment.
        cyc(1'b0, 1'b0, 1'b1, 8'h05, 8'h43, mk(8'h05, 8'h43, 8'h00, 0, 0, 0, 1, 0));
        pulses(21, 0, 8'h05, 8'h43, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
        idle(3, mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));

        // Drain the scoreboard within a bounded number of cycles.
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d entries left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
